// File: rtl/gpr_file_param.sv
// gpr_file_param
//   General-purpose register file: one write port, two combinational read
//   ports, optional hardwired-zero entry 0, optional same-cycle write-to-read
//   forwarding, and a sequenced bulk-clear engine that zeroes one entry per
//   cycle.
// Ports
//   clk, rst                      clock, async active-high reset
//   reg_write_en/_wr_addr/_wr_data  write port (ignored while clr_busy)
//   reg_rd_addr_n / reg_rd_data_n   combinational read ports (n = 1, 2)
//   clr_req                       level request, sampled only in IDLE
//   clr_busy                      sweep in progress (exactly DEPTH cycles)
//   clr_done                      one-cycle pulse after the sweep

// Per-port read mux. Kept separate so every read port gets identical
// zero/bypass/array priority.
module gpr_file_param_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] i_regs,
  input  logic                               i_byp_vld,
  input  logic [ADDR_W-1:0]                  i_wr_addr,
  input  logic [DATA_W-1:0]                  i_wr_data,
  output logic [DATA_W-1:0]                  o_data
);
  logic w_byp_hit;
  logic w_zero_hit;

  assign w_byp_hit  = BYPASS && i_byp_vld && (i_wr_addr == i_addr);
  assign w_zero_hit = ZERO_REG && (i_addr == '0);

  // Zero entry wins over bypass, bypass wins over the stored value.
  always_comb begin
    o_data = i_regs[i_addr];
    if (w_byp_hit)  o_data = i_wr_data;
    if (w_zero_hit) o_data = '0;
  end
endmodule

module gpr_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_wr_addr,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic [ADDR_W-1:0] reg_rd_addr_1,
  output logic [DATA_W-1:0] reg_rd_data_1,
  input  logic [ADDR_W-1:0] reg_rd_addr_2,
  output logic [DATA_W-1:0] reg_rd_data_2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NUM_RD = 2;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [ADDR_W-1:0]             r_idx;
  logic [DEPTH-1:0][DATA_W-1:0]  r_regs;

  logic                          w_busy;
  logic                          w_done;
  logic                          w_wr_ok;
  logic                          w_byp_vld;
  logic                          w_sweep_last;
  logic [NUM_RD-1:0][ADDR_W-1:0] w_rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_sweep_last = (r_idx == ADDR_W'(DEPTH-1));

  // Status outputs depend on the registered state only, so they carry no
  // combinational path from any input.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        w_busy = 1'b1;
        if (w_sweep_last) w_state_nxt = S_DONE;
      end
      // DONE always returns to IDLE; a still-high clr_req must be seen
      // again in IDLE before another sweep starts.
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign clr_busy = w_busy;
  assign clr_done = w_done;

  // Sweep index: armed to 0 on entry, advances once per CLEAR cycle. The
  // increment past DEPTH-1 wraps harmlessly since the FSM leaves CLEAR there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_idx <= '0;
    else if (r_state == S_IDLE && clr_req)   r_idx <= '0;
    else if (w_busy)                         r_idx <= r_idx + ADDR_W'(1);
  end

  // ---------------------------------------------------------------- array
  assign w_wr_ok   = reg_write_en && !w_busy &&
                     !(ZERO_REG && (reg_wr_addr == '0));
  // Forwarding follows the same busy gating as the write itself, so a read
  // never shows data that will not land.
  assign w_byp_vld = reg_write_en && !w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_regs <= '0;
    else if (w_busy)  r_regs[r_idx] <= '0;
    else if (w_wr_ok) r_regs[reg_wr_addr] <= reg_wr_data;
  end

  // ---------------------------------------------------------------- reads
  assign w_rd_addr[0] = reg_rd_addr_1;
  assign w_rd_addr[1] = reg_rd_addr_2;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    gpr_file_param_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .i_addr   (w_rd_addr[g]),
      .i_regs   (r_regs),
      .i_byp_vld(w_byp_vld),
      .i_wr_addr(reg_wr_addr),
      .i_wr_data(reg_wr_data),
      .o_data   (w_rd_data[g])
    );
  end

  assign reg_rd_data_1 = w_rd_data[0];
  assign reg_rd_data_2 = w_rd_data[1];
endmodule

// File: tb/tb_gpr_file_param.sv
module tb_gpr_file_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  // default-parameter DUT (u0) and BYPASS=0 DUT (u1) share the same inputs
  logic        we = 0, clr_req = 0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wd = '0;
  logic [31:0] d0_1, d0_2, d1_1, d1_2;
  logic        b0, dn0, b1, dn1;

  // small DUT: DATA_W=16, ADDR_W=3, ZERO_REG=0
  logic        we_s = 0, clr_req_s = 0;
  logic [2:0]  wa_s = '0, ra1_s = '0, ra2_s = '0;
  logic [15:0] wd_s = '0;
  logic [15:0] ds_1, ds_2;
  logic        b_s, dn_s;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] model[32];
  logic [31:0] exp_v;

  gpr_file_param u0 (
    .clk(clk), .rst(rst), .reg_write_en(we), .reg_wr_addr(wa), .reg_wr_data(wd),
    .reg_rd_addr_1(ra1), .reg_rd_data_1(d0_1), .reg_rd_addr_2(ra2), .reg_rd_data_2(d0_2),
    .clr_req(clr_req), .clr_busy(b0), .clr_done(dn0));

  gpr_file_param #(.BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .reg_write_en(we), .reg_wr_addr(wa), .reg_wr_data(wd),
    .reg_rd_addr_1(ra1), .reg_rd_data_1(d1_1), .reg_rd_addr_2(ra2), .reg_rd_data_2(d1_2),
    .clr_req(clr_req), .clr_busy(b1), .clr_done(dn1));

  gpr_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u2 (
    .clk(clk), .rst(rst), .reg_write_en(we_s), .reg_wr_addr(wa_s), .reg_wr_data(wd_s),
    .reg_rd_addr_1(ra1_s), .reg_rd_data_1(ds_1), .reg_rd_addr_2(ra2_s), .reg_rd_data_2(ds_2),
    .clr_req(clr_req_s), .clr_busy(b_s), .clr_done(dn_s));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    sb.push_back(32'h0);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, b0 | dn0} !== exp_v) begin
      failures++; $display("FAIL reset_status got busy=%b done=%b exp 0 0", b0, dn0);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      sb.push_back(model[a]); sb.push_back(model[31 - a]);
      @(negedge clk);
      exp_v = sb.pop_front(); checks++;
      if (d0_1 !== exp_v) begin failures++; $display("FAIL reset_rd1[%0d] got=%h exp=%h", a, d0_1, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (d0_2 !== exp_v) begin failures++; $display("FAIL reset_rd2[%0d] got=%h exp=%h", 31 - a, d0_2, exp_v); end
    end
  endtask

  task automatic test_write();
    tick();
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick(); model[5] = 32'hDEADBEEF;
    wa = 31; wd = 32'h80000001;
    tick(); model[31] = 32'h80000001;
    we = 0; ra1 = 5; ra2 = 31;
    sb.push_back(model[5]); sb.push_back(model[31]); sb.push_back(model[5]);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL write_x5 got=%h exp=%h", d0_1, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d0_2 !== exp_v) begin failures++; $display("FAIL write_x31 got=%h exp=%h", d0_2, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d1_1 !== exp_v) begin failures++; $display("FAIL write_x5_nobyp got=%h exp=%h", d1_1, exp_v); end
    tick();
    we = 1; wa = 0; wd = 32'h1234;
    tick();
    we = 0; ra1 = 0; ra2 = 0;
    sb.push_back(32'h0); sb.push_back(32'h0);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL write_x0_rd1 got=%h exp=%h", d0_1, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d0_2 !== exp_v) begin failures++; $display("FAIL write_x0_rd2 got=%h exp=%h", d0_2, exp_v); end
  endtask

  task automatic test_bypass();
    tick();
    we = 1; wa = 7; wd = 32'h11;
    tick(); model[7] = 32'h11;
    wd = 32'hA5A5A5A5; ra2 = 7; ra1 = 5;
    sb.push_back(32'hA5A5A5A5); sb.push_back(model[7]); sb.push_back(model[5]);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (d0_2 !== exp_v) begin failures++; $display("FAIL bypass_rd2 got=%h exp=%h", d0_2, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d1_2 !== exp_v) begin failures++; $display("FAIL nobypass_rd2 got=%h exp=%h", d1_2, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL bypass_other_port got=%h exp=%h", d0_1, exp_v); end
    tick(); model[7] = 32'hA5A5A5A5;
    wa = 0; wd = 32'hFFFF; ra1 = 0; ra2 = 7;
    sb.push_back(32'h0); sb.push_back(model[7]);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL bypass_x0 got=%h exp=%h", d0_1, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d1_2 !== exp_v) begin failures++; $display("FAIL nobypass_after_write got=%h exp=%h", d1_2, exp_v); end
    tick(); we = 0;
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 1; i < 32; i++) begin
      we = 1; wa = 5'(i); wd = 32'(i);
      tick(); model[i] = 32'(i);
    end
    we = 0; ra1 = 17;
    sb.push_back(model[17]);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL fill_x17 got=%h exp=%h", d0_1, exp_v); end
    tick(); clr_req = 1;
    tick(); clr_req = 0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!b0) break;
      if (cnt == 10) begin
        // sweep at idx 10: x3 already cleared, x20 not yet; write to x3 must neither land nor forward
        we = 1; wa = 3; wd = 32'h99; ra1 = 3; ra2 = 20;
        sb.push_back(32'h0); sb.push_back(32'd20);
        #1;
        exp_v = sb.pop_front(); checks++;
        if (d0_1 !== exp_v) begin failures++; $display("FAIL midsweep_x3 got=%h exp=%h", d0_1, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if (d0_2 !== exp_v) begin failures++; $display("FAIL midsweep_x20 got=%h exp=%h", d0_2, exp_v); end
        @(posedge clk); #1 we = 0;
      end
      cnt++;
    end
    sb.push_back(32'd32); sb.push_back(32'h1); sb.push_back(32'h1);
    exp_v = sb.pop_front(); checks++;
    if (32'(cnt) !== exp_v) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", cnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, dn0} !== exp_v) begin failures++; $display("FAIL clear_done_pulse got=%b exp=%0d", dn0, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, dn1} !== exp_v) begin failures++; $display("FAIL clear_done_pulse_u1 got=%b exp=%0d", dn1, exp_v); end
    @(negedge clk);
    sb.push_back(32'h0);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, dn0 | b0} !== exp_v) begin failures++; $display("FAIL clear_done_width got done=%b busy=%b exp 0 0", dn0, b0); end
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a);
      sb.push_back(model[a]); sb.push_back(model[a]);
      @(negedge clk);
      exp_v = sb.pop_front(); checks++;
      if (d0_1 !== exp_v) begin failures++; $display("FAIL cleared_rd1[%0d] got=%h exp=%h", a, d0_1, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (d1_2 !== exp_v) begin failures++; $display("FAIL cleared_u1_rd2[%0d] got=%h exp=%h", a, d1_2, exp_v); end
    end
  endtask

  task automatic test_corner();
    int cnt;
    int bad;
    tick();
    we = 1; wa = 9; wd = 32'h55; clr_req = 1;
    tick(); we = 0; ra1 = 9;
    sb.push_back(32'h55);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL corner_write_landed got=%h exp=%h", d0_1, exp_v); end
    cnt = b0 ? 1 : 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!b0) break;
      cnt++;
    end
    sb.push_back(32'd32); sb.push_back(32'h1);
    exp_v = sb.pop_front(); checks++;
    if (32'(cnt) !== exp_v) begin failures++; $display("FAIL corner_busy_cycles got=%0d exp=%0d", cnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, dn0} !== exp_v) begin failures++; $display("FAIL corner_done got=%b exp=%0d", dn0, exp_v); end
    // clr_req still high across the DONE->IDLE edge; dropped in IDLE
    tick(); clr_req = 0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (b0 || dn0) bad++;
    end
    sb.push_back(32'h0); sb.push_back(32'h0);
    exp_v = sb.pop_front(); checks++;
    if (32'(bad) !== exp_v) begin failures++; $display("FAIL corner_no_restart got=%0d bad cycles exp=%0d", bad, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d0_1 !== exp_v) begin failures++; $display("FAIL corner_x9_cleared got=%h exp=%h", d0_1, exp_v); end
  endtask

  task automatic test_small();
    int cnt;
    tick();
    we_s = 1; wa_s = 0; wd_s = 16'hBEEF;
    tick(); wa_s = 7; wd_s = 16'h7777;
    tick(); we_s = 0; ra1_s = 0; ra2_s = 7;
    sb.push_back(32'hBEEF); sb.push_back(32'h7777);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if ({16'h0, ds_1} !== exp_v) begin failures++; $display("FAIL small_x0 got=%h exp=%h", ds_1, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({16'h0, ds_2} !== exp_v) begin failures++; $display("FAIL small_x7 got=%h exp=%h", ds_2, exp_v); end
    tick(); we_s = 1; wa_s = 0; wd_s = 16'h1111;
    sb.push_back(32'h1111);
    @(negedge clk);
    exp_v = sb.pop_front(); checks++;
    if ({16'h0, ds_1} !== exp_v) begin failures++; $display("FAIL small_bypass_x0 got=%h exp=%h", ds_1, exp_v); end
    tick(); we_s = 0; clr_req_s = 1;
    tick(); clr_req_s = 0;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!b_s) break;
      cnt++;
    end
    sb.push_back(32'd8); sb.push_back(32'h1);
    exp_v = sb.pop_front(); checks++;
    if (32'(cnt) !== exp_v) begin failures++; $display("FAIL small_busy_cycles got=%0d exp=%0d", cnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, dn_s} !== exp_v) begin failures++; $display("FAIL small_done got=%b exp=%0d", dn_s, exp_v); end
    for (int a = 0; a < 8; a++) begin
      ra1_s = 3'(a);
      sb.push_back(32'h0);
      @(negedge clk);
      exp_v = sb.pop_front(); checks++;
      if ({16'h0, ds_1} !== exp_v) begin failures++; $display("FAIL small_cleared[%0d] got=%h exp=%h", a, ds_1, exp_v); end
    end
  endtask

  task automatic test_abort();
    int cnt;
    int bad;
    bit hit;
    tick();
    we = 1; wa = 20; wd = 32'h2020;
    tick(); wa = 25; wd = 32'h2525;
    tick(); we = 0; clr_req = 1;
    tick(); clr_req = 0;
    cnt = 0; hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!b0) break;
      if (cnt == 10) begin
        rst = 1'b1; hit = 1;
        #1;
        sb.push_back(32'h0);
        exp_v = sb.pop_front(); checks++;
        if ({31'h0, b0 | dn0} !== exp_v) begin failures++; $display("FAIL abort_immediate got busy=%b done=%b exp 0 0", b0, dn0); end
        break;
      end
      cnt++;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_reach_idx10 got busy_cycles=%0d exp>=11", cnt); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dn0 || b0) bad++;
    end
    sb.push_back(32'h0);
    exp_v = sb.pop_front(); checks++;
    if (32'(bad) !== exp_v) begin failures++; $display("FAIL abort_no_done got=%0d bad cycles exp=%0d", bad, exp_v); end
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a);
      sb.push_back(model[a]); sb.push_back(model[a]);
      @(negedge clk);
      exp_v = sb.pop_front(); checks++;
      if (d0_1 !== exp_v) begin failures++; $display("FAIL abort_rd1[%0d] got=%h exp=%h", a, d0_1, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (d0_2 !== exp_v) begin failures++; $display("FAIL abort_rd2[%0d] got=%h exp=%h", a, d0_2, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_clear();
    test_corner();
    test_small();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
